serial_adder_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell, which is instantiated internally.
- Accepts WIDTH-bit operands over a valid/ready handshake.
- Feeds the full adder one bit per clock, LSB first, and holds the carry in a flop between bits.
- Presents the WIDTH-bit result, carry-out and signed-overflow flag over a second valid/ready handshake.
- Trades WIDTH cycles of latency for one adder cell; used wherever area matters more than throughput.

---
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, operands fed LSB first,
// carry held in a flop between bits, result returned over a valid/ready handshake.

module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              c_msb_q, c_msb_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              fa_s, fa_c;

    serial_adder_fa u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b here, seed carry with 1.
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 2)) begin
                    c_msb_d = fa_c;
                end
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cout_d  = fa_c;
                    ovf_d   = fa_c ^ c_msb_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: 8-bit vectors with hand-computed results
// plus an exhaustive 4-bit sweep against a small arithmetic model.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, sub8, cout8, ovf8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, cin4, sub4, cout4, ovf4, busy4;
    logic [3:0] a4, b4, sum4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8),
        .busy      (busy8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .sub       (sub4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4),
        .busy      (busy4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Accept one operation on dut8 and wait (bounded) for out_valid; lat = edges after E0.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                           input logic tsub, output int lat);
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tcin; sub8 = tsub; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tcin,
                           input logic tsub, output int lat);
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tcin; sub4 = tsub; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    initial begin
        int         lat;
        int         seen;
        logic [3:0] bb, s_exp;
        logic [4:0] r;
        logic       co_exp, ov_exp;

        rst_n = 1'b0;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready8, 1);
        check_eq("rst_out_valid", out_valid8, 0);
        check_eq("rst_sum", sum8, 0);
        check_eq("rst_cout_ovf", {cout8, ovf8}, 0);
        check_eq("rst_busy", busy8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op8(8'h0F, 8'h01, 0, 0, lat);
        check_eq("add_lat", lat, 8);
        check_eq("add_busy", busy8, 1);
        check_eq("add_res", {sum8, cout8, ovf8}, {8'h10, 1'b0, 1'b0});
        handoff8();

        run_op8(8'hFF, 8'h00, 1, 0, lat);
        check_eq("wrap_res", {sum8, cout8, ovf8}, {8'h00, 1'b1, 1'b0});
        handoff8();

        run_op8(8'h7F, 8'h01, 0, 0, lat);
        check_eq("sovf_res", {sum8, cout8, ovf8}, {8'h80, 1'b0, 1'b1});
        handoff8();

        run_op8(8'h05, 8'h07, 1, 1, lat);
        check_eq("sub_borrow", {sum8, cout8, ovf8}, {8'hFE, 1'b0, 1'b0});
        handoff8();

        // Back-pressure on 0x80-1: result must hold while out_ready is low.
        run_op8(8'h80, 8'h01, 0, 1, lat);
        check_eq("sub_ovf", {sum8, cout8, ovf8}, {8'h7F, 1'b1, 1'b1});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", {out_valid8, in_ready8, sum8, cout8, ovf8},
                     {1'b1, 1'b0, 8'h7F, 1'b1, 1'b1});
        end
        handoff8();
        check_eq("bp_release", {out_valid8, in_ready8}, {1'b0, 1'b1});
        check_eq("sum_kept_idle", sum8, 8'h7F);

        // in_valid with junk operands during RUN must be ignored.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 0; sub8 = 0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h55;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid8 = 1'b0;
        check_eq("ign_lat", lat, 8);
        check_eq("ign_res", sum8, 8'h02);
        handoff8();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        check_eq("ign_no_extra", seen, 0);

        // Asynchronous reset three edges into RUN.
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 0; sub8 = 0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_state", {in_ready8, out_valid8, busy8}, {1'b1, 1'b0, 1'b0});
        check_eq("arst_res", {sum8, cout8, ovf8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid8 || !in_ready8) seen++;
        end
        check_eq("arst_quiet", seen, 0);
        run_op8(8'h03, 8'h04, 0, 0, lat);
        check_eq("arst_fresh_lat", lat, 8);
        check_eq("arst_fresh_res", {sum8, cout8, ovf8}, {8'h07, 1'b0, 1'b0});
        handoff8();

        // Exhaustive 4-bit sweep; one packed comparison per operation.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    for (int is = 0; is < 2; is++) begin
                        bb     = is[0] ? ~ib[3:0] : ib[3:0];
                        r      = {1'b0, ia[3:0]} + {1'b0, bb} + {4'b0, (is[0] ? 1'b1 : ic[0])};
                        s_exp  = r[3:0];
                        co_exp = r[4];
                        ov_exp = (ia[3] == bb[3]) && (s_exp[3] != ia[3]);
                        run_op4(ia[3:0], ib[3:0], ic[0], is[0], lat);
                        check_eq($sformatf("sweep a=%0h b=%0h c=%0d s=%0d", ia, ib, ic, is),
                                 {lat[7:0], sum4, cout4, ovf4},
                                 {8'd4, s_exp, co_exp, ov_exp});
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
